cve2_crash_dump_tx: RTL and testbench

//  Reader/transmitter end of the core crash-dump interface. On a trigger it snapshots crash_dump_t

---
 rtl/cve2_crash_dump_tx_pkg.sv | 30 +++
 rtl/cve2_crash_dump_tx_if.sv | 23 ++
 rtl/cve2_word_serializer.sv | 48 ++++
 rtl/cve2_crash_dump_tx.sv | 140 ++++++++++++++
 tb/tb_cve2_crash_dump_tx.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cve2_crash_dump_tx_pkg.sv
// Shared types and constants for the crash-dump transmitter.
// Captured fields, frame sync byte and FSM state encoding live here.
package cve2_crash_dump_tx_pkg;

    // Sync byte in the top byte of the frame header word
    localparam logic [7:0] CRASH_DUMP_SYNC = 8'hCD;

    // Header plus four captured addresses; the checksum word is extra
    localparam int unsigned CRASH_DUMP_WORDS_BASE = 5;

    typedef enum logic {
        CDTX_IDLE,
        CDTX_SEND
    } crash_dump_tx_state_e;

    // Same layout as the core's crash_dump_t (first member in the top bits)
    typedef struct packed {
        logic [31:0] current_pc;
        logic [31:0] next_pc;
        logic [31:0] last_data_addr;
        logic [31:0] exception_addr;
    } crash_dump_t;

    typedef logic [6:0] exc_cause_t;

    function automatic logic [31:0] header_word(input exc_cause_t cause);
        return {CRASH_DUMP_SYNC, 17'd0, cause};
    endfunction

endpackage

// File: rtl/cve2_crash_dump_tx_if.sv
// Valid/ready beat link from the crash-dump transmitter to a debug/trace sink.
interface cve2_crash_dump_tx_if #(
    parameter int unsigned BeatWidth = 8
);
    logic                 valid;
    logic [BeatWidth-1:0] data;
    logic                 last;
    logic                 ready;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/cve2_word_serializer.sv
// Splits one 32-bit word into 32/BeatWidth beats, least-significant beat first,
// presented on a valid/ready link. A load overrides any beat in progress.
module cve2_word_serializer #(
    parameter int unsigned BeatWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          word,
    input  logic                 load,
    output logic                 valid,
    output logic [BeatWidth-1:0] data,
    output logic                 last_beat,
    input  logic                 ready
);
    localparam int unsigned Beats = 32 / BeatWidth;
    localparam int unsigned IdxW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Beats - 1);

    logic [31:0]     shift_q;
    logic [IdxW-1:0] idx_q;
    logic            valid_q;

    // Load a new word, or shift down one beat per accepted handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= word;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready) begin
            if (idx_q == LastIdx) begin
                // Keep the final beat on data; only valid drops
                valid_q <= 1'b0;
            end else begin
                shift_q <= shift_q >> BeatWidth;
                idx_q   <= idx_q + 1'b1;
            end
        end
    end

    assign valid     = valid_q;
    assign data      = shift_q[BeatWidth-1:0];
    assign last_beat = valid_q && (idx_q == LastIdx);

endmodule

// File: rtl/cve2_crash_dump_tx.sv
// Crash-dump transmitter: on a trigger, snapshots the crash dump and exception
// cause into a frame buffer and streams the frame out as narrow beats.
// Optional feature: define CVE2_CRASH_DUMP_CHK_EN to append an XOR checksum word.
module cve2_crash_dump_tx
    import cve2_crash_dump_tx_pkg::*;
#(
    parameter int unsigned BeatWidth = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        dump_trig_i,
    input  crash_dump_t                 crash_dump_i,
    input  logic [6:0]                  exc_cause_i,
    cve2_crash_dump_tx_if.master        tx,
    output logic                        busy_o,
    output logic [7:0]                  drop_cnt_o,
    input  logic                        clr_drop_i
);

    if (!(BeatWidth == 8 || BeatWidth == 16 || BeatWidth == 32)) begin : g_bad_width
        $error("cve2_crash_dump_tx: BeatWidth must be 8, 16 or 32");
    end

`ifdef CVE2_CRASH_DUMP_CHK_EN
    localparam int unsigned NumWords = CRASH_DUMP_WORDS_BASE + 1;
`else
    localparam int unsigned NumWords = CRASH_DUMP_WORDS_BASE;
`endif
    localparam logic [2:0] LastWord = 3'(NumWords - 1);

    crash_dump_tx_state_e state_q;
    logic [31:0]          frame_q [NumWords];
    logic [2:0]           word_idx_q;
    logic                 busy_q;
    logic [7:0]           drop_cnt_q;

    logic [31:0] cap_words [NumWords];
    logic        capture;
    logic        last_word;
    logic        beat_done;
    logic        word_done;
    logic        frame_done;
    logic [2:0]  next_idx;
    logic        ser_load;
    logic [31:0] ser_word;
    logic        ser_last_beat;

    // Words as they would be captured this cycle
    always_comb begin
        cap_words[0] = header_word(exc_cause_i);
        cap_words[1] = crash_dump_i.current_pc;
        cap_words[2] = crash_dump_i.next_pc;
        cap_words[3] = crash_dump_i.last_data_addr;
        cap_words[4] = crash_dump_i.exception_addr;
`ifdef CVE2_CRASH_DUMP_CHK_EN
        cap_words[5] = header_word(exc_cause_i) ^ crash_dump_i.current_pc ^
                       crash_dump_i.next_pc ^ crash_dump_i.last_data_addr ^
                       crash_dump_i.exception_addr;
`endif
    end

    assign capture    = (state_q == CDTX_IDLE) && en_i && dump_trig_i;
    assign last_word  = (word_idx_q == LastWord);
    assign beat_done  = tx.valid && tx.ready;
    assign word_done  = beat_done && ser_last_beat && !last_word;
    assign frame_done = beat_done && ser_last_beat && last_word;
    assign next_idx   = word_idx_q + 3'd1;

    // W0 bypasses the buffer because it is loaded in the capture cycle itself
    assign ser_load = capture || ((state_q == CDTX_SEND) && word_done);
    assign ser_word = capture ? cap_words[0] : frame_q[next_idx];

    cve2_word_serializer #(
        .BeatWidth (BeatWidth)
    ) u_serializer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .word      (ser_word),
        .load      (ser_load),
        .valid     (tx.valid),
        .data      (tx.data),
        .last_beat (ser_last_beat),
        .ready     (tx.ready)
    );

    assign tx.last = ser_last_beat && last_word;

    // Frame FSM: capture into the buffer, then walk the words until the last beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CDTX_IDLE;
            word_idx_q <= '0;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < NumWords; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                CDTX_IDLE: begin
                    if (capture) begin
                        state_q    <= CDTX_SEND;
                        busy_q     <= 1'b1;
                        word_idx_q <= '0;
                        for (int unsigned i = 0; i < NumWords; i++) begin
                            frame_q[i] <= cap_words[i];
                        end
                    end
                end
                CDTX_SEND: begin
                    if (frame_done) begin
                        state_q <= CDTX_IDLE;
                        busy_q  <= 1'b0;
                    end else if (word_done) begin
                        word_idx_q <= next_idx;
                    end
                end
                default: begin
                    state_q <= CDTX_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Count triggers that arrive while a frame is in flight; clear has priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else if (clr_drop_i) begin
            drop_cnt_q <= '0;
        end else if (dump_trig_i && (state_q != CDTX_IDLE) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign busy_o     = busy_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_cve2_crash_dump_tx.sv
// Scoreboard bench for cve2_crash_dump_tx: stimulus pushes the expected beats of
// each frame, independent monitors pop and compare every accepted beat.
module tb_cve2_crash_dump_tx;
    import cve2_crash_dump_tx_pkg::*;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic en     = 1'b0;
    logic trig   = 1'b0;
    logic trig32 = 1'b0;
    logic clr    = 1'b0;
    crash_dump_t cd;
    logic [6:0]  cause;
    logic        busy, busy32;
    logic [7:0]  drop, drop32;

    int total = 0;
    int bad   = 0;

    cve2_crash_dump_tx_if #(.BeatWidth(8))  tx();
    cve2_crash_dump_tx_if #(.BeatWidth(32)) tx32();

    always #5 clk = ~clk;

    cve2_crash_dump_tx #(.BeatWidth(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .en_i         (en),
        .dump_trig_i  (trig),
        .crash_dump_i (cd),
        .exc_cause_i  (cause),
        .tx           (tx),
        .busy_o       (busy),
        .drop_cnt_o   (drop),
        .clr_drop_i   (clr)
    );

    cve2_crash_dump_tx #(.BeatWidth(32)) dut32 (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .en_i         (en),
        .dump_trig_i  (trig32),
        .crash_dump_i (cd),
        .exc_cause_i  (cause),
        .tx           (tx32),
        .busy_o       (busy32),
        .drop_cnt_o   (drop32),
        .clr_drop_i   (clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame as a list of words, cut into LSB-first beats
    logic [8:0]  exp_q[$];
    logic [32:0] exp32_q[$];

    task automatic expect_frame(input logic [6:0] c, input crash_dump_t d, input bit wide);
        logic [31:0] w[$];
        logic [31:0] x;
        int          n;
        w.push_back({8'hCD, 17'd0, c});
        w.push_back(d.current_pc);
        w.push_back(d.next_pc);
        w.push_back(d.last_data_addr);
        w.push_back(d.exception_addr);
`ifdef CVE2_CRASH_DUMP_CHK_EN
        w.push_back(w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4]);
`endif
        n = w.size();
        for (int i = 0; i < n; i++) begin
            x = w[i];
            if (wide) begin
                exp32_q.push_back({(i == n - 1), x});
            end else begin
                for (int b = 0; b < 4; b++) begin
                    exp_q.push_back({((i == n - 1) && (b == 3)), x[8*b +: 8]});
                end
            end
        end
    endtask

    // Monitor for the 8-bit link: stall stability and scoreboard pop
    int         beats_seen = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    logic [8:0] e;

    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", tx.valid, 1'b1);
                check("stall_data_held", tx.data, prev_data);
                check("stall_last_held", tx.last, prev_last);
            end
            if (tx.valid && tx.ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h with nothing expected", tx.data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", tx.data, e[7:0]);
                    check("beat_last", tx.last, e[8]);
                    beats_seen++;
                end
            end
            prev_stall = tx.valid && !tx.ready;
            prev_data  = tx.data;
            prev_last  = tx.last;
        end
    end

    logic [32:0] e32;

    always @(negedge clk) begin
        if (rst_ni && tx32.valid && tx32.ready) begin
            if (exp32_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat32: got data %0h with nothing expected", tx32.data);
            end else begin
                e32 = exp32_q.pop_front();
                check("beat32_data", tx32.data, e32[31:0]);
                check("beat32_last", tx32.last, e32[32]);
            end
        end
    end

    // Ready driver: fixed level or random stalls, changed just after each edge
    bit rand_ready = 1'b0;
    bit ready_fix  = 1'b1;

    initial begin
        tx.ready   = 1'b1;
        tx32.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx.ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_fix;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fire(input logic [6:0] c, input crash_dump_t d);
        cause = c;
        cd    = d;
        trig  = 1'b1;
        expect_frame(c, d, 1'b0);
        tick(1);
        trig = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            tick(1);
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_valid_low"}, tx.valid, 1'b0);
    endtask

    function automatic crash_dump_t rand_cd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    crash_dump_t f_cd;

    initial begin
        f_cd = '{current_pc: 32'h1000, next_pc: 32'h1004,
                 last_data_addr: 32'h2000_0010, exception_addr: 32'h100};
        cause = 7'h02;
        cd    = f_cd;
        en    = 1'b1;
        tick(2);
        check("rst_valid", tx.valid, 1'b0);
        check("rst_data", tx.data, 8'h00);
        check("rst_last", tx.last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop, 8'h00);
        check("rst_valid32", tx32.valid, 1'b0);
        check("rst_drop32", drop32, 8'h00);
        rst_ni = 1'b1;
        tick(2);

        // Reference frame, sink always ready; valid must appear one cycle after capture
        fire(7'h02, f_cd);
        check("t1_valid_n1", tx.valid, 1'b1);
        check("t1_first_data", tx.data, 8'h02);
        check("t1_busy", busy, 1'b1);
        drain("t1");

        // Same frame under random stalls
        rand_ready = 1'b1;
        fire(7'h02, f_cd);
        drain("t3");
        rand_ready = 1'b0;
        tick(1);

        // Three dropped triggers mid-frame
        fire(7'h02, f_cd);
        tick(5);
        trig = 1'b1;
        tick(3);
        trig = 1'b0;
        drain("t4");
        check("t4_drop3", drop, 8'd3);

        // Saturation with the sink stalled; mid-frame input changes must not matter
        ready_fix = 1'b0;
        tick(2);
        cause = 7'h11;
        cd    = rand_cd();
        trig  = 1'b1;
        expect_frame(cause, cd, 1'b0);
        for (int i = 0; i < 301; i++) begin
            tick(1);
            cd    = rand_cd();
            cause = 7'($urandom);
        end
        trig = 1'b0;
        check("t4_drop_sat", drop, 8'hFF);
        check("t4_stalled_valid", tx.valid, 1'b1);
        clr  = 1'b1;
        trig = 1'b1;
        tick(1);
        clr  = 1'b0;
        trig = 1'b0;
        check("t4_clr_wins", drop, 8'h00);
        ready_fix = 1'b1;
        drain("t4b");

        // Reset mid-frame after the seventh beat
        beats_seen = 0;
        fire(7'($urandom), rand_cd());
        for (int n = 0; n < 100 && beats_seen < 7; n++) tick(1);
        check("t5_beats_before_rst", beats_seen, 7);
        rst_ni = 1'b0;
        #1;
        check("t5_rst_valid", tx.valid, 1'b0);
        check("t5_rst_last", tx.last, 1'b0);
        check("t5_rst_data", tx.data, 8'h00);
        check("t5_rst_busy", busy, 1'b0);
        exp_q.delete();
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        fire(7'($urandom), rand_cd());
        drain("t5");

        // Disabled: trigger in IDLE is ignored and not counted
        en   = 1'b0;
        trig = 1'b1;
        tick(5);
        trig = 1'b0;
        tick(2);
        check("t6_busy", busy, 1'b0);
        check("t6_valid", tx.valid, 1'b0);
        check("t6_drop", drop, 8'h00);
        en = 1'b1;

        // Random frames, random stalls, enable dropped mid-frame
        for (int k = 0; k < 4; k++) begin
            rand_ready = 1'b1;
            fire(7'($urandom), rand_cd());
            tick(3);
            en = 1'b0;
            drain("rand");
            en = 1'b1;
            rand_ready = 1'b0;
            tick(1);
        end

        // 32-bit beats: one beat per word
        cause  = 7'h02;
        cd     = f_cd;
        trig32 = 1'b1;
        expect_frame(7'h02, f_cd, 1'b1);
        tick(1);
        trig32 = 1'b0;
        check("w32_valid_n1", tx32.valid, 1'b1);
        check("w32_first_data", tx32.data, 32'hCD00_0002);
        for (int n = 0; n < 50 && (exp32_q.size() != 0 || busy32); n++) tick(1);
        check("w32_drain", exp32_q.size(), 0);
        check("w32_busy", busy32, 1'b0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
